// File: rtl/core_pkg.sv
// Shared RV32E core definitions: datapath widths, load funct3 encodings
// and the writeback-stage state type.
package core_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 4;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      WB_IDLE      = 1'b0,
      WB_WAIT_LOAD = 1'b1
   } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word from an aligned memory word and
// sign- or zero-extends it according to the load funct3.
module load_extract
   import core_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] value_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output of a combinational block gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      byte_sel = rdata_i[7:0];
      case (addr_lo_i)
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         2'd3:    byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      // Halfword selection only looks at addr_lo[1].
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      value_o = rdata_i;
      case (funct3_i)
         F3_LB:   value_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  value_o = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   value_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  value_o = {{(XLEN-16){1'b0}}, half_sel};
         F3_LW:   value_o = rdata_i;
         default: value_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// RV32E writeback stage: retires ALU results, waits for load responses and
// issues one registered register-file write per writing instruction.
module wb_stage
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic [XLEN-1:0]      ex_result,
   input  logic                 ex_is_load,
   input  logic [2:0]           ex_funct3,
   input  logic [1:0]           ex_addr_lo,
   input  logic                 dmem_rvalid,
   input  logic [XLEN-1:0]      dmem_rdata,
   output logic                 rf_we,
   output logic [REG_IDX_W-1:0] rf_rd,
   output logic [XLEN-1:0]      rf_rd_data,
   output logic                 load_busy,
   output logic [REG_IDX_W-1:0] load_rd,
   output logic                 err_timeout
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   wb_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [REG_IDX_W-1:0] ld_rd_q, ld_rd_d;
   logic [2:0]           ld_f3_q, ld_f3_d;
   logic [1:0]           ld_lo_q, ld_lo_d;
   logic                 rf_we_q, rf_we_d;
   logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]      rf_data_q, rf_data_d;
   logic                 err_q, err_d;
   logic [XLEN-1:0]      load_value;

   load_extract u_extract (
      .funct3_i  (ld_f3_q),
      .addr_lo_i (ld_lo_q),
      .rdata_i   (dmem_rdata),
      .value_o   (load_value)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ld_rd_d   = ld_rd_q;
      ld_f3_d   = ld_f3_q;
      ld_lo_d   = ld_lo_q;
      rf_we_d   = 1'b0;
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
      err_d     = err_q;

      case (state_q)
         WB_IDLE: begin
            if (ex_valid) begin
               if (ex_is_load) begin
                  state_d = WB_WAIT_LOAD;
                  ld_rd_d = ex_rd;
                  ld_f3_d = ex_funct3;
                  ld_lo_d = ex_addr_lo;
                  cnt_d   = '0;
               end else if (ex_rd != '0) begin
                  rf_we_d   = 1'b1;
                  rf_rd_d   = ex_rd;
                  rf_data_d = ex_result;
               end
            end
         end
         WB_WAIT_LOAD: begin
            if (dmem_rvalid) begin
               state_d = WB_IDLE;
               if (ld_rd_q != '0) begin
                  rf_we_d   = 1'b1;
                  rf_rd_d   = ld_rd_q;
                  rf_data_d = load_value;
               end
            end else if (TIMEOUT_CYCLES != 0) begin
               // Abort on the edge where the miss count reaches the limit.
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_LIMIT) begin
                  state_d = WB_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge value, independent of statement order.
   // NOTE: the latched load fields are reset too, so load_rd reads 0 out of
   // reset and no stale destination is visible to the hazard unit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= WB_IDLE;
         cnt_q     <= '0;
         ld_rd_q   <= '0;
         ld_f3_q   <= '0;
         ld_lo_q   <= '0;
         rf_we_q   <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ld_rd_q   <= ld_rd_d;
         ld_f3_q   <= ld_f3_d;
         ld_lo_q   <= ld_lo_d;
         rf_we_q   <= rf_we_d;
         rf_rd_q   <= rf_rd_d;
         rf_data_q <= rf_data_d;
         err_q     <= err_d;
      end
   end

   assign ex_ready    = (state_q == WB_IDLE);
   assign load_busy   = (state_q == WB_WAIT_LOAD);
   assign load_rd     = ld_rd_q;
   assign rf_we       = rf_we_q;
   assign rf_rd       = rf_rd_q;
   assign rf_rd_data  = rf_data_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage (TIMEOUT_CYCLES=4) and standalone load_extract:
// vector tables, directed corner sequences and a randomized model check.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [3:0]  ex_rd;
   logic [31:0] ex_result;
   logic        ex_is_load;
   logic [2:0]  ex_funct3;
   logic [1:0]  ex_addr_lo;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        rf_we;
   logic [3:0]  rf_rd;
   logic [31:0] rf_rd_data;
   logic        load_busy;
   logic [3:0]  load_rd;
   logic        err_timeout;

   logic [2:0]  x_f3;
   logic [1:0]  x_lo;
   logic [31:0] x_rdata;
   logic [31:0] x_value;

   int checks = 0;
   int errors = 0;

   // Model of the last write actually issued; hold checks only when known.
   logic [3:0]  last_rd;
   logic [31:0] last_data;
   bit          hold_valid;

   always #5 clk = ~clk;

   wb_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_rd       (ex_rd),
      .ex_result   (ex_result),
      .ex_is_load  (ex_is_load),
      .ex_funct3   (ex_funct3),
      .ex_addr_lo  (ex_addr_lo),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .rf_we       (rf_we),
      .rf_rd       (rf_rd),
      .rf_rd_data  (rf_rd_data),
      .load_busy   (load_busy),
      .load_rd     (load_rd),
      .err_timeout (err_timeout)
   );

   load_extract u_ext (
      .funct3_i  (x_f3),
      .addr_lo_i (x_lo),
      .rdata_i   (x_rdata),
      .value_o   (x_value)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Reference extraction from the load rules, using shifts and arithmetic.
   function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
      logic [31:0] r;
      int unsigned bsh;
      int unsigned hsh;
      bsh = 8 * lo;
      hsh = (lo >= 2) ? 16 : 0;
      case (f3)
         3'b000:  r = 32'($signed(w << (24 - bsh)) >>> 24);
         3'b100:  r = (w >> bsh) & 32'h0000_00FF;
         3'b001:  r = 32'($signed(w << (16 - hsh)) >>> 16);
         3'b101:  r = (w >> hsh) & 32'h0000_FFFF;
         default: r = w;
      endcase
      return r;
   endfunction

   task automatic idle_cycle();
      @(negedge clk);
      check("idle_we", 32'(rf_we), 32'd0);
      if (hold_valid) begin
         check("hold_rd", 32'(rf_rd), 32'(last_rd));
         check("hold_data", rf_rd_data, last_data);
      end
   endtask

   task automatic alu_op(input logic [3:0] rd, input logic [31:0] res);
      ex_valid   = 1'b1;
      ex_is_load = 1'b0;
      ex_rd      = rd;
      ex_result  = res;
      check("alu_ready", 32'(ex_ready), 32'd1);
      @(negedge clk);
      ex_valid = 1'b0;
      check("alu_we", 32'(rf_we), 32'(rd != 4'd0));
      if (rd != 4'd0) begin
         check("alu_rd", 32'(rf_rd), 32'(rd));
         check("alu_data", rf_rd_data, res);
         last_rd    = rd;
         last_data  = res;
         hold_valid = 1'b1;
      end else begin
         hold_valid = 1'b0;
      end
   endtask

   // Load with `delay` response-less WAIT_LOAD cycles before the rvalid pulse.
   task automatic load_op(input logic [2:0] f3, input logic [1:0] lo, input logic [3:0] rd,
                          input logic [31:0] data, input int delay, input logic [31:0] exp);
      ex_valid   = 1'b1;
      ex_is_load = 1'b1;
      ex_rd      = rd;
      ex_funct3  = f3;
      ex_addr_lo = lo;
      ex_result  = $urandom;
      check("ld_ready", 32'(ex_ready), 32'd1);
      @(negedge clk);
      ex_valid = 1'b0;
      check("ld_busy", 32'(load_busy), 32'd1);
      check("ld_rd", 32'(load_rd), 32'(rd));
      check("ld_stall", 32'(ex_ready), 32'd0);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         check("ld_wait_busy", 32'(load_busy), 32'd1);
         check("ld_wait_we", 32'(rf_we), 32'd0);
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = data;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      check("ld_we", 32'(rf_we), 32'(rd != 4'd0));
      check("ld_done_busy", 32'(load_busy), 32'd0);
      check("ld_done_ready", 32'(ex_ready), 32'd1);
      if (rd != 4'd0) begin
         check("ld_wr_rd", 32'(rf_rd), 32'(rd));
         check("ld_data", rf_rd_data, exp);
         last_rd    = rd;
         last_data  = exp;
         hold_valid = 1'b1;
      end else begin
         hold_valid = 1'b0;
      end
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] rdata;
      logic [31:0] exp;
   } ext_vec_t;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [3:0]  rd;
      logic [31:0] rdata;
      logic [31:0] exp;
   } ld_vec_t;

   ext_vec_t ext_tab[15];
   ld_vec_t  ld_tab[6];

   initial begin
      ext_tab[0]  = '{3'b000, 2'd3, 32'h8012_3456, 32'hFFFF_FF80};
      ext_tab[1]  = '{3'b100, 2'd3, 32'h8012_3456, 32'h0000_0080};
      ext_tab[2]  = '{3'b000, 2'd0, 32'h8012_3456, 32'h0000_0056};
      ext_tab[3]  = '{3'b000, 2'd1, 32'h8012_3456, 32'h0000_0034};
      ext_tab[4]  = '{3'b000, 2'd2, 32'h8012_3456, 32'h0000_0012};
      ext_tab[5]  = '{3'b000, 2'd0, 32'h0000_00F0, 32'hFFFF_FFF0};
      ext_tab[6]  = '{3'b001, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001};
      ext_tab[7]  = '{3'b101, 2'd2, 32'h8001_7FFF, 32'h0000_8001};
      ext_tab[8]  = '{3'b001, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF};
      ext_tab[9]  = '{3'b001, 2'd3, 32'h8001_7FFF, 32'hFFFF_8001};
      ext_tab[10] = '{3'b101, 2'd1, 32'h8001_F00F, 32'h0000_F00F};
      ext_tab[11] = '{3'b010, 2'd1, 32'h8001_7FFF, 32'h8001_7FFF};
      ext_tab[12] = '{3'b011, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D};
      ext_tab[13] = '{3'b110, 2'd3, 32'hCAFE_F00D, 32'hCAFE_F00D};
      ext_tab[14] = '{3'b111, 2'd1, 32'h8000_0080, 32'h8000_0080};

      ld_tab[0] = '{3'b000, 2'd3, 4'd7, 32'h8012_3456, 32'hFFFF_FF80};
      ld_tab[1] = '{3'b100, 2'd3, 4'd7, 32'h8012_3456, 32'h0000_0080};
      ld_tab[2] = '{3'b001, 2'd2, 4'd8, 32'h8001_7FFF, 32'hFFFF_8001};
      ld_tab[3] = '{3'b101, 2'd2, 4'd8, 32'h8001_7FFF, 32'h0000_8001};
      ld_tab[4] = '{3'b010, 2'd1, 4'd9, 32'h8001_7FFF, 32'h8001_7FFF};
      ld_tab[5] = '{3'b000, 2'd1, 4'd0, 32'h8012_3456, 32'h0000_0034};

      rst = 1'b1;
      ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_is_load = 1'b0;
      ex_funct3 = '0; ex_addr_lo = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      x_f3 = '0; x_lo = '0; x_rdata = '0;
      last_rd = '0; last_data = '0; hold_valid = 1'b1;

      #1;
      check("rst_we", 32'(rf_we), 32'd0);
      check("rst_rd", 32'(rf_rd), 32'd0);
      check("rst_data", rf_rd_data, 32'd0);
      check("rst_busy", 32'(load_busy), 32'd0);
      check("rst_load_rd", 32'(load_rd), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_ready", 32'(ex_ready), 32'd1);

      // Standalone extractor: table, then random against the model.
      foreach (ext_tab[i]) begin
         x_f3 = ext_tab[i].f3; x_lo = ext_tab[i].lo; x_rdata = ext_tab[i].rdata;
         #1;
         check($sformatf("ext_tab%0d", i), x_value, ext_tab[i].exp);
      end
      for (int i = 0; i < 60; i++) begin
         x_f3 = 3'($urandom); x_lo = 2'($urandom); x_rdata = $urandom;
         #1;
         check("ext_rand", x_value, ref_extract(x_f3, x_lo, x_rdata));
      end

      @(negedge clk);
      rst = 1'b0;
      idle_cycle();

      // Single retire, then three back-to-back retires, then pulse/hold.
      alu_op(4'd5, 32'hDEAD_BEEF);
      alu_op(4'd1, 32'h1111_1111);
      alu_op(4'd2, 32'h2222_2222);
      alu_op(4'd15, 32'h3333_3333);
      idle_cycle();
      idle_cycle();

      foreach (ld_tab[i])
         load_op(ld_tab[i].f3, ld_tab[i].lo, ld_tab[i].rd, ld_tab[i].rdata, 2, ld_tab[i].exp);
      // x0 targets: no write, but the x0 load still blocks until rvalid.
      alu_op(4'd0, 32'hFFFF_FFFF);
      load_op(3'b010, 2'd0, 4'd0, 32'h1234_5678, 3, 32'h1234_5678);
      load_op(3'b010, 2'd0, 4'd4, 32'hA5A5_5A5A, 0, 32'hA5A5_5A5A);
      // Stray rvalid in IDLE is ignored.
      dmem_rvalid = 1'b1;
      idle_cycle();
      dmem_rvalid = 1'b0;

      // Randomized mix against the model; at most 3 misses keeps clear of timeout.
      for (int n = 0; n < 80; n++) begin
         logic [3:0]  rd;
         logic [31:0] w;
         logic [2:0]  f3;
         logic [1:0]  lo;
         rd = 4'($urandom);
         w  = $urandom;
         f3 = 3'($urandom);
         lo = 2'($urandom);
         if ($urandom_range(0, 1) == 0) alu_op(rd, w);
         else load_op(f3, lo, rd, w, int'($urandom_range(0, 3)), ref_extract(f3, lo, w));
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end

      // Timeout: load to x9, no response for 4 WAIT_LOAD cycles.
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd9; ex_funct3 = 3'b010; ex_addr_lo = 2'd0;
      @(negedge clk);
      ex_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_busy", 32'(load_busy), 32'd1);
         check("to_err_early", 32'(err_timeout), 32'd0);
         check("to_we_wait", 32'(rf_we), 32'd0);
         @(negedge clk);
      end
      check("to_busy_clear", 32'(load_busy), 32'd0);
      check("to_ready", 32'(ex_ready), 32'd1);
      check("to_err", 32'(err_timeout), 32'd1);
      check("to_we", 32'(rf_we), 32'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h5555_AAAA;
      idle_cycle();
      dmem_rvalid = 1'b0;
      check("to_stray_busy", 32'(load_busy), 32'd0);
      check("to_err_sticky", 32'(err_timeout), 32'd1);
      alu_op(4'd6, 32'h0BAD_CAFE);
      check("to_err_sticky2", 32'(err_timeout), 32'd1);

      // Reset while a load to x10 is outstanding.
      alu_op(4'd3, 32'h1234_5678);
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd10; ex_funct3 = 3'b010; ex_addr_lo = 2'd0;
      @(negedge clk);
      ex_valid = 1'b0;
      check("mr_busy_pre", 32'(load_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mr_we", 32'(rf_we), 32'd0);
      check("mr_rd", 32'(rf_rd), 32'd0);
      check("mr_data", rf_rd_data, 32'd0);
      check("mr_busy", 32'(load_busy), 32'd0);
      check("mr_load_rd", 32'(load_rd), 32'd0);
      check("mr_err", 32'(err_timeout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_rd = '0; last_data = '0; hold_valid = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h7777_7777;
      idle_cycle();
      dmem_rvalid = 1'b0;
      check("mr_after_busy", 32'(load_busy), 32'd0);
      idle_cycle();
      alu_op(4'd11, 32'hFEED_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
